decode_stage: RTL and testbench

Registered, parametrised RV32I instruction-decode pipeline stage. It sits between the fetch stage and the execute stage. It decodes one instruction per cycle into the control fields the datapath already uses, and holds them in an ID/EX register with a valid/ready handshake. It also adds:
- load-use hazard interlock
- flush
- illegal-instruction detection
- optional M-extension decode
- a saturating stall counter

---
 rtl/decode_stage.sv | 222 ++++++++++++++++++++++
 tb/tb_decode_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I instruction decode stage with a registered ID/EX output and a valid/ready handshake.
// It also provides a load-use interlock, flush, illegal-instruction detection, optional
// M-extension decode and a saturating count of the hazard bubbles it inserts.
// Field encodings:
//   aluop[3:0]: NONE=0 ADD=1 SUB=2 SLL=3 SLT=4 SLTU=5 XOR=6 SRL=7 SRA=8 OR=9 AND=10
//               EQU=11 NEQ=12 SGE=13 SGEU=14; aluop[4]=1 marks an M op with funct3 in [2:0]
//   alu_s*: ZERO=0 RS1=1 RS2=2 IMM=3   pc_select: PLUS4=0 PCIMM=1 ALU=2 BRANCH=3
//   rd_select: ALU=0 MEM=1 PCPLUS4=2 PCIMM=3   mem_type: INT8=0 INT16=1 INT32=2 UINT8=4 UINT16=5
module decode_stage #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ENABLE_M    = 0,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   if_valid_i,
  input  logic [31:0]            if_instr_i,
  input  logic [XLEN-1:0]        if_pc_i,
  output logic                   if_ready_o,
  input  logic                   flush_i,
  input  logic                   ex_ready_i,
  output logic                   id_valid_o,
  output logic [XLEN-1:0]        id_pc_o,
  output logic [4:0]             rs1_o,
  output logic [4:0]             rs2_o,
  output logic [4:0]             rd_o,
  output logic [XLEN-1:0]        imm_o,
  output logic [4:0]             aluop_o,
  output logic [1:0]             alu_s1_o,
  output logic [1:0]             alu_s2_o,
  output logic [1:0]             pc_select_o,
  output logic                   mem_read_o,
  output logic                   mem_write_o,
  output logic [2:0]             mem_type_o,
  output logic [1:0]             rd_select_o,
  output logic                   rd_write_o,
  output logic                   illegal_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam logic [3:0] ALUOP_NONE = 4'd0,  ALUOP_ADD  = 4'd1,  ALUOP_SUB  = 4'd2,
                         ALUOP_SLL  = 4'd3,  ALUOP_SLT  = 4'd4,  ALUOP_SLTU = 4'd5,
                         ALUOP_XOR  = 4'd6,  ALUOP_SRL  = 4'd7,  ALUOP_SRA  = 4'd8,
                         ALUOP_OR   = 4'd9,  ALUOP_AND  = 4'd10, ALUOP_EQU  = 4'd11,
                         ALUOP_NEQ  = 4'd12, ALUOP_SGE  = 4'd13, ALUOP_SGEU = 4'd14;
  localparam logic [1:0] SRC_ZERO = 2'd0, SRC_RS1 = 2'd1, SRC_RS2 = 2'd2, SRC_IMM = 2'd3;
  localparam logic [1:0] PC_PLUS4 = 2'd0, PC_PCIMM = 2'd1, PC_ALU = 2'd2, PC_BRANCH = 2'd3;
  localparam logic [1:0] RD_ALU = 2'd0, RD_MEM = 2'd1, RD_PCPLUS4 = 2'd2, RD_PCIMM = 2'd3;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL   = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [31:0]     imm32;
  logic [4:0]      d_aluop;
  logic [1:0]      d_s1, d_s2, d_pc, d_rd_sel;
  logic            d_mem_read, d_mem_write, d_rd_write, d_illegal;
  logic            uses_rs1, uses_rs2;
  logic            out_free, hazard, accept;

  assign opcode = if_instr_i[6:0];
  assign funct3 = if_instr_i[14:12];
  assign funct7 = if_instr_i[31:25];

  // Shared OP/OP-IMM funct3 mapping; alt selects SUB/SRA.
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  arith_op = alt ? ALUOP_SUB : ALUOP_ADD;
      3'b001:  arith_op = ALUOP_SLL;
      3'b010:  arith_op = ALUOP_SLT;
      3'b011:  arith_op = ALUOP_SLTU;
      3'b100:  arith_op = ALUOP_XOR;
      3'b101:  arith_op = alt ? ALUOP_SRA : ALUOP_SRL;
      3'b110:  arith_op = ALUOP_OR;
      default: arith_op = ALUOP_AND;
    endcase
  endfunction

  // Decode the incoming instruction into datapath control fields.
  always_comb begin
    d_aluop     = {1'b0, ALUOP_NONE};
    d_s1        = SRC_ZERO;
    d_s2        = SRC_ZERO;
    d_pc        = PC_PLUS4;
    d_rd_sel    = RD_ALU;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    d_rd_write  = 1'b0;
    d_illegal   = 1'b0;
    imm32       = '0;
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
    case (opcode)
      OP_LUI: begin
        d_s1 = SRC_IMM; d_aluop = {1'b0, ALUOP_ADD}; d_rd_write = 1'b1;
        imm32 = {if_instr_i[31:12], 12'b0};
      end
      OP_AUIPC: begin
        d_rd_sel = RD_PCIMM; d_rd_write = 1'b1;
        imm32 = {if_instr_i[31:12], 12'b0};
      end
      OP_JAL: begin
        d_pc = PC_PCIMM; d_rd_sel = RD_PCPLUS4; d_rd_write = 1'b1;
        imm32 = {{11{if_instr_i[31]}}, if_instr_i[31], if_instr_i[19:12], if_instr_i[20],
                 if_instr_i[30:21], 1'b0};
      end
      OP_JALR: begin
        d_pc = PC_ALU; d_s1 = SRC_RS1; d_s2 = SRC_IMM; d_aluop = {1'b0, ALUOP_ADD};
        d_rd_sel = RD_PCPLUS4; d_rd_write = 1'b1; uses_rs1 = 1'b1;
        imm32 = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
      end
      OP_BRANCH: begin
        d_s1 = SRC_RS1; d_s2 = SRC_RS2; d_pc = PC_BRANCH; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        imm32 = {{19{if_instr_i[31]}}, if_instr_i[31], if_instr_i[7], if_instr_i[30:25],
                 if_instr_i[11:8], 1'b0};
        case (funct3)
          3'b000:  d_aluop = {1'b0, ALUOP_EQU};
          3'b001:  d_aluop = {1'b0, ALUOP_NEQ};
          3'b100:  d_aluop = {1'b0, ALUOP_SLT};
          3'b101:  d_aluop = {1'b0, ALUOP_SGE};
          3'b110:  d_aluop = {1'b0, ALUOP_SLTU};
          3'b111:  d_aluop = {1'b0, ALUOP_SGEU};
          default: d_illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        d_s1 = SRC_RS1; d_s2 = SRC_IMM; d_aluop = {1'b0, ALUOP_ADD}; d_mem_read = 1'b1;
        d_rd_sel = RD_MEM; d_rd_write = 1'b1; uses_rs1 = 1'b1;
        imm32 = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
        d_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        d_s1 = SRC_RS1; d_s2 = SRC_IMM; d_aluop = {1'b0, ALUOP_ADD}; d_mem_write = 1'b1;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        imm32 = {{20{if_instr_i[31]}}, if_instr_i[31:25], if_instr_i[11:7]};
        d_illegal = funct3[2] || (funct3 == 3'b011);
      end
      OP_IMM: begin
        d_s1 = SRC_RS1; d_s2 = SRC_IMM; d_rd_write = 1'b1; uses_rs1 = 1'b1;
        imm32 = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
        d_aluop = {1'b0, arith_op(funct3, (funct3 == 3'b101) && if_instr_i[30])};
        if (funct3 == 3'b001)
          d_illegal = (funct7 != 7'b0000000);
        else if (funct3 == 3'b101)
          d_illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      OP_REG: begin
        d_s1 = SRC_RS1; d_s2 = SRC_RS2; d_rd_write = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        if (funct7 == 7'b0000000)
          d_aluop = {1'b0, arith_op(funct3, 1'b0)};
        else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
          d_aluop = {1'b0, arith_op(funct3, 1'b1)};
        else if (funct7 == 7'b0000001 && ENABLE_M != 0)
          d_aluop = {2'b10, funct3};
        else
          d_illegal = 1'b1;
      end
      default: d_illegal = 1'b1;
    endcase
    if (d_illegal) begin
      d_aluop     = {1'b0, ALUOP_NONE};
      d_pc        = PC_PLUS4;
      d_mem_read  = 1'b0;
      d_mem_write = 1'b0;
      d_rd_write  = 1'b0;
      imm32       = '0;
    end
    if (if_instr_i[11:7] == 5'd0) d_rd_write = 1'b0;
  end

  assign out_free   = !id_valid_o || ex_ready_i;
  assign hazard     = id_valid_o && mem_read_o && (rd_o != 5'd0) && if_valid_i &&
                      ((uses_rs1 && (if_instr_i[19:15] == rd_o)) ||
                       (uses_rs2 && (if_instr_i[24:20] == rd_o)));
  assign if_ready_o = out_free && !hazard && !flush_i;
  assign accept     = if_valid_i && if_ready_o;

  // Valid bit and bubble counter; a bubble is a free slot refused only because of the interlock.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      id_valid_o  <= 1'b0;
      stall_cnt_o <= '0;
    end else if (flush_i) begin
      id_valid_o <= 1'b0;
    end else if (accept) begin
      id_valid_o <= 1'b1;
    end else if (out_free) begin
      id_valid_o <= 1'b0;
      if (hazard && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + STALL_CNT_W'(1);
    end
  end

  // ID/EX payload register, loaded only on an accepted instruction.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      id_pc_o <= '0; rs1_o <= '0; rs2_o <= '0; rd_o <= '0; imm_o <= '0; aluop_o <= '0;
      alu_s1_o <= '0; alu_s2_o <= '0; pc_select_o <= '0; mem_read_o <= 1'b0;
      mem_write_o <= 1'b0; mem_type_o <= '0; rd_select_o <= '0; rd_write_o <= 1'b0;
      illegal_o <= 1'b0;
    end else if (!flush_i && accept) begin
      id_pc_o     <= if_pc_i;
      rs1_o       <= if_instr_i[19:15];
      rs2_o       <= if_instr_i[24:20];
      rd_o        <= if_instr_i[11:7];
      imm_o       <= XLEN'($signed(imm32));
      aluop_o     <= d_aluop;
      alu_s1_o    <= d_s1;
      alu_s2_o    <= d_s2;
      pc_select_o <= d_pc;
      mem_read_o  <= d_mem_read;
      mem_write_o <= d_mem_write;
      mem_type_o  <= funct3;
      rd_select_o <= d_rd_sel;
      rd_write_o  <= d_rd_write;
      illegal_o   <= d_illegal;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one instance without M decode (16-bit counter) and one
// with M decode and a 1-bit counter, both driven by the same fetch/execute stimulus.
module tb_decode_stage;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        if_valid_i;
  logic [31:0] if_instr_i;
  logic [31:0] if_pc_i;
  logic        flush_i;
  logic        ex_ready_i;

  logic        if_ready, id_valid, mem_read, mem_write, rd_write, illegal;
  logic [31:0] id_pc, imm;
  logic [4:0]  rs1, rs2, rd, aluop;
  logic [1:0]  alu_s1, alu_s2, pc_select, rd_select;
  logic [2:0]  mem_type;
  logic [15:0] stall_cnt;

  logic        m_if_ready, m_id_valid, m_mem_read, m_mem_write, m_rd_write, m_illegal;
  logic [31:0] m_id_pc, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd, m_aluop;
  logic [1:0]  m_alu_s1, m_alu_s2, m_pc_select, m_rd_select;
  logic [2:0]  m_mem_type;
  logic [0:0]  m_stall_cnt;

  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk_i = ~clk_i;

  decode_stage #(.XLEN(32), .ENABLE_M(0), .STALL_CNT_W(16)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .if_valid_i(if_valid_i), .if_instr_i(if_instr_i),
    .if_pc_i(if_pc_i), .if_ready_o(if_ready), .flush_i(flush_i), .ex_ready_i(ex_ready_i),
    .id_valid_o(id_valid), .id_pc_o(id_pc), .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd),
    .imm_o(imm), .aluop_o(aluop), .alu_s1_o(alu_s1), .alu_s2_o(alu_s2),
    .pc_select_o(pc_select), .mem_read_o(mem_read), .mem_write_o(mem_write),
    .mem_type_o(mem_type), .rd_select_o(rd_select), .rd_write_o(rd_write),
    .illegal_o(illegal), .stall_cnt_o(stall_cnt)
  );

  decode_stage #(.XLEN(32), .ENABLE_M(1), .STALL_CNT_W(1)) dut_m (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .if_valid_i(if_valid_i), .if_instr_i(if_instr_i),
    .if_pc_i(if_pc_i), .if_ready_o(m_if_ready), .flush_i(flush_i), .ex_ready_i(ex_ready_i),
    .id_valid_o(m_id_valid), .id_pc_o(m_id_pc), .rs1_o(m_rs1), .rs2_o(m_rs2), .rd_o(m_rd),
    .imm_o(m_imm), .aluop_o(m_aluop), .alu_s1_o(m_alu_s1), .alu_s2_o(m_alu_s2),
    .pc_select_o(m_pc_select), .mem_read_o(m_mem_read), .mem_write_o(m_mem_write),
    .mem_type_o(m_mem_type), .rd_select_o(m_rd_select), .rd_write_o(m_rd_write),
    .illegal_o(m_illegal), .stall_cnt_o(m_stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    if_valid_i = 1'b1;
    if_instr_i = instr;
    if_pc_i    = pc;
  endtask

  initial begin
    rst_n_i = 1'b0; if_valid_i = 1'b0; if_instr_i = '0; if_pc_i = '0;
    flush_i = 1'b0; ex_ready_i = 1'b1;
    #12;
    check("rst_valid", id_valid, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_imm", imm, 0);
    check("rst_aluop", aluop, 0);
    check("rst_rd_write", rd_write, 0);
    rst_n_i = 1'b1;

    // Back-to-back ADDI x1,x0,5 then ADD x2,x1,x1
    present(32'h0050_0093, 32'h100);
    #1 check("addi_ready", if_ready, 1);
    step();
    check("addi_valid", id_valid, 1);
    check("addi_imm", imm, 5);
    check("addi_aluop", aluop, 5'd1);
    check("addi_s1", alu_s1, 2'd1);
    check("addi_s2", alu_s2, 2'd3);
    check("addi_rd_write", rd_write, 1);
    check("addi_rd", rd, 1);
    check("addi_pc", id_pc, 32'h100);
    present(32'h0010_8133, 32'h104);
    step();
    check("add_valid", id_valid, 1);
    check("add_rd", rd, 2);
    check("add_rs2", rs2, 1);
    check("add_s2", alu_s2, 2'd2);
    check("add_imm", imm, 0);
    check("add_pc", id_pc, 32'h104);
    check("add_stall", stall_cnt, 0);

    // Load-use: LW x5,0(x1) then ADD x6,x5,x0
    present(32'h0000_A283, 32'h108);
    step();
    check("lw_mem_read", mem_read, 1);
    check("lw_mem_type", mem_type, 3'd2);
    check("lw_rd_sel", rd_select, 2'd1);
    check("lw_rd", rd, 5);
    present(32'h0002_8333, 32'h10C);
    #1 check("lu_ready", if_ready, 0);
    step();
    check("lu_bubble_valid", id_valid, 0);
    check("lu_stall", stall_cnt, 1);
    check("lu_ready_after", if_ready, 1);
    step();
    check("lu_dep_valid", id_valid, 1);
    check("lu_dep_rd", rd, 6);
    check("lu_dep_mem_read", mem_read, 0);

    // Same pair with rd=x0: no interlock
    present(32'h0000_A003, 32'h110);
    step();
    check("lw0_rd_write", rd_write, 0);
    check("lw0_mem_read", mem_read, 1);
    present(32'h0000_0333, 32'h114);
    #1 check("lw0_ready", if_ready, 1);
    step();
    check("lw0_dep_valid", id_valid, 1);
    check("lw0_dep_rd", rd, 6);
    check("lw0_stall", stall_cnt, 1);

    // Execute back-pressure for three cycles
    ex_ready_i = 1'b0;
    present(32'h0050_0093, 32'h118);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", if_ready, 0);
      check("bp_valid", id_valid, 1);
      check("bp_rd", rd, 6);
      check("bp_pc", id_pc, 32'h114);
      check("bp_stall", stall_cnt, 1);
      step();
    end
    ex_ready_i = 1'b1;
    #1 check("bp_release_ready", if_ready, 1);
    step();
    check("bp_accept_rd", rd, 1);
    check("bp_accept_pc", id_pc, 32'h118);

    // Flush with a valid input: refused, output killed
    flush_i = 1'b1;
    present(32'h0010_8133, 32'h11C);
    #1 check("flush_ready", if_ready, 0);
    step();
    check("flush_valid", id_valid, 0);
    check("flush_rd_held", rd, 1);
    check("flush_stall", stall_cnt, 1);
    flush_i = 1'b0;
    step();
    check("post_flush_valid", id_valid, 1);
    check("post_flush_rd", rd, 2);

    // MUL x3,x1,x2 with and without M decode
    present(32'h0220_81B3, 32'h120);
    step();
    check("mul_nom_illegal", illegal, 1);
    check("mul_nom_rd_write", rd_write, 0);
    check("mul_nom_aluop", aluop, 0);
    check("mul_m_illegal", m_illegal, 0);
    check("mul_m_aluop", m_aluop, 5'b10000);
    check("mul_m_rd_write", m_rd_write, 1);

    // Control flow and an unknown opcode
    present(32'h0080_00EF, 32'h124);
    step();
    check("jal_pc_sel", pc_select, 2'd1);
    check("jal_imm", imm, 8);
    check("jal_rd_sel", rd_select, 2'd2);
    check("jal_rd_write", rd_write, 1);
    present(32'h0000_8067, 32'h128);
    step();
    check("jalr_pc_sel", pc_select, 2'd2);
    check("jalr_imm", imm, 0);
    check("jalr_aluop", aluop, 5'd1);
    check("jalr_rd_write", rd_write, 0);
    present(32'hFE20_F8E3, 32'h12C);
    step();
    check("bgeu_pc_sel", pc_select, 2'd3);
    check("bgeu_imm", imm, 32'hFFFF_FFF0);
    check("bgeu_aluop", aluop, 5'd14);
    check("bgeu_s2", alu_s2, 2'd2);
    present(32'h0000_007F, 32'h130);
    step();
    check("op7f_illegal", illegal, 1);
    check("op7f_pc_sel", pc_select, 0);
    check("op7f_imm", imm, 0);
    check("op7f_aluop", aluop, 0);

    // Second bubble: 16-bit counter reaches 2, 1-bit counter saturates at 1
    present(32'h0000_A283, 32'h134);
    step();
    present(32'h0002_8333, 32'h138);
    step();
    check("sat_valid", id_valid, 0);
    check("sat_stall16", stall_cnt, 2);
    check("sat_stall1", m_stall_cnt, 1);
    step();
    check("sat_dep_rd", rd, 6);

    // Asynchronous reset discards the in-flight instruction at once
    rst_n_i = 1'b0;
    #1;
    check("arst_valid", id_valid, 0);
    check("arst_stall", stall_cnt, 0);
    check("arst_rd", rd, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
